// File: rtl/phase_sweep_controller.sv
// Phase sweep controller: drives sample_clk_ce and phase_increment of the
// LUT sine generator. The sample enable comes from a free-running clk divider.
// The increment steps linearly from start to stop and holds each step for
// dwell+1 sample pulses. It runs as a single up-sweep or as a continuous
// triangle sweep.
// Optional feature: define PHASE_SWEEP_CYCLE_COUNT_EN to add the sweep_cycles
// output, which counts completed triangles and saturates at 16'hFFFF.
module phase_sweep_controller #(
  parameter int PHASE_WIDTH  = 64,
  parameter int CE_DIV_WIDTH = 16,
  parameter int DWELL_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [CE_DIV_WIDTH-1:0] ce_divider,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode,
  input  logic [PHASE_WIDTH-1:0]  start_increment,
  input  logic [PHASE_WIDTH-1:0]  stop_increment,
  input  logic [PHASE_WIDTH-1:0]  step_increment,
  input  logic [DWELL_WIDTH-1:0]  dwell_samples,
  output logic                    sample_clk_ce,
  output logic [PHASE_WIDTH-1:0]  phase_increment,
  output logic                    busy,
  output logic                    done
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
  ,
  output logic [15:0]             sweep_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t                  state;
  logic [CE_DIV_WIDTH-1:0] div_cnt;
  logic [DWELL_WIDTH-1:0]  dwell_cnt;
  logic [PHASE_WIDTH-1:0]  start_s;
  logic [PHASE_WIDTH-1:0]  stop_s;
  logic [PHASE_WIDTH-1:0]  step_s;
  logic [DWELL_WIDTH-1:0]  dwell_s;
  logic                    mode_s;
  logic                    accept;

  // The sum carries one extra bit so that an overflow past 2^W still clamps to the bound.
  function automatic logic [PHASE_WIDTH-1:0] sat_add(
    input logic [PHASE_WIDTH-1:0] a,
    input logic [PHASE_WIDTH-1:0] b,
    input logic [PHASE_WIDTH-1:0] lim
  );
    logic [PHASE_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[PHASE_WIDTH-1:0];
  endfunction

  // A set borrow bit means the difference went below zero, so clamp to the bound.
  function automatic logic [PHASE_WIDTH-1:0] sat_sub(
    input logic [PHASE_WIDTH-1:0] a,
    input logic [PHASE_WIDTH-1:0] b,
    input logic [PHASE_WIDTH-1:0] lim
  );
    logic [PHASE_WIDTH:0] s;
    s = {1'b0, a} - {1'b0, b};
    return (s[PHASE_WIDTH] || (s[PHASE_WIDTH-1:0] < lim)) ? lim : s[PHASE_WIDTH-1:0];
  endfunction

  assign accept = (state == IDLE) && start && !abort;

  // Free-running divider. The pulse is registered, so it is low during reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      div_cnt       <= '0;
      sample_clk_ce <= 1'b0;
    end else if (div_cnt == ce_divider) begin
      div_cnt       <= '0;
      sample_clk_ce <= 1'b1;
    end else begin
      div_cnt       <= div_cnt + 1'b1;
      sample_clk_ce <= 1'b0;
    end
  end

  // Latch the sweep parameters when a sweep is accepted. A zero step becomes one full-range jump.
  always_ff @(posedge clk) begin
    if (accept) begin
      start_s <= start_increment;
      stop_s  <= stop_increment;
      step_s  <= (step_increment == '0) ? (stop_increment - start_increment) : step_increment;
      dwell_s <= dwell_samples;
      mode_s  <= mode;
    end
  end

  // Sweep FSM. Steps advance only on sample enables, so the generator never sees a value change mid-sample.
  always_ff @(posedge clk) begin
    if (arst) begin
      state           <= IDLE;
      phase_increment <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dwell_cnt       <= '0;
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
      sweep_cycles    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              phase_increment <= start_increment;
              dwell_cnt       <= '0;
              busy            <= 1'b1;
              state           <= UP;
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
              sweep_cycles    <= '0;
`endif
            end
          end
          UP, DOWN: begin
            if (sample_clk_ce) begin
              if (dwell_cnt != dwell_s) begin
                dwell_cnt <= dwell_cnt + 1'b1;
              end else begin
                dwell_cnt <= '0;
                if (state == UP) begin
                  if (phase_increment >= stop_s) begin
                    if (!mode_s) begin
                      done  <= 1'b1;
                      busy  <= 1'b0;
                      state <= IDLE;
                    end else begin
                      state <= DOWN;
                    end
                  end else begin
                    phase_increment <= sat_add(phase_increment, step_s, stop_s);
                  end
                end else begin
                  if (phase_increment <= start_s) begin
                    state <= UP;
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
                    if (sweep_cycles != 16'hFFFF) sweep_cycles <= sweep_cycles + 16'd1;
`endif
                  end else begin
                    phase_increment <= sat_sub(phase_increment, step_s, start_s);
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sweep_controller.sv
// Bench for phase_sweep_controller. A queue-based reference model predicts
// every output on every cycle. Directed sweeps are also pinned against
// hand-computed value sequences.
module tb_phase_sweep_controller;

  logic        clk = 1'b0;
  logic        arst;
  logic [15:0] ce_divider;
  logic        start, abort, mode;
  logic [63:0] start_increment, stop_increment, step_increment;
  logic [15:0] dwell_samples;
  logic        sample_clk_ce;
  logic [63:0] phase_increment;
  logic        busy, done;
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
  logic [15:0] sweep_cycles;
`endif

  int checks = 0;
  int errors = 0;

  phase_sweep_controller dut (
    .clk(clk), .arst(arst), .ce_divider(ce_divider), .start(start), .abort(abort),
    .mode(mode), .start_increment(start_increment), .stop_increment(stop_increment),
    .step_increment(step_increment), .dwell_samples(dwell_samples),
    .sample_clk_ce(sample_clk_ce), .phase_increment(phase_increment),
    .busy(busy), .done(done)
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
    , .sweep_cycles(sweep_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the sweep is a precomputed list of step values.
  logic [63:0] seq[$];
  bit          endd[$];
  int          k, held, idx, m_dwell, m_cyc;
  bit          m_ce, m_busy, m_done, m_mode;
  logic [63:0] m_pi;

  task automatic build(input logic [63:0] s, input logic [63:0] e, input logic [63:0] st, input bit md);
    logic [63:0] stp, v;
    logic [63:0] u[$];
    logic [63:0] d[$];
    stp = (st == 0) ? e - s : st;
    v = s;
    u.push_back(v);
    while (v < e && u.size() < 1000) begin
      if (e - v <= stp) v = e; else v = v + stp;
      u.push_back(v);
    end
    v = u[u.size()-1];
    d.push_back(v);
    while (v > s && d.size() < 1000) begin
      if (v - s <= stp) v = s; else v = v - stp;
      d.push_back(v);
    end
    seq.delete(); endd.delete();
    foreach (u[i]) begin seq.push_back(u[i]); endd.push_back(1'b0); end
    if (md) begin
      while (seq.size() < 300) begin
        foreach (d[i]) begin seq.push_back(d[i]); endd.push_back(i == d.size()-1); end
        foreach (u[i]) begin seq.push_back(u[i]); endd.push_back(1'b0); end
      end
    end
  endtask

  always @(posedge clk) begin
    bit ce_now;
    if (arst) begin
      k = 0; m_ce = 0; m_pi = 0; m_busy = 0; m_done = 0; m_cyc = 0;
    end else begin
      ce_now = m_ce;
      k++;
      m_ce = ((k % (int'(ce_divider) + 1)) == 0);
      m_done = 0;
      if (abort) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          build(start_increment, stop_increment, step_increment, mode);
          m_busy = 1; idx = 0; held = 0; m_pi = seq[0];
          m_dwell = int'(dwell_samples); m_mode = mode; m_cyc = 0;
        end
      end else if (ce_now) begin
        if (held == m_dwell) begin
          held = 0;
          if (idx == seq.size() - 1) begin
            if (!m_mode) begin m_done = 1; m_busy = 0; end
          end else begin
            if (endd[idx] && m_cyc < 65535) m_cyc++;
            idx++;
            m_pi = seq[idx];
          end
        end else begin
          held++;
        end
      end
    end
  end

  // Every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    chk("ce", sample_clk_ce, m_ce);
    chk("phase_increment", phase_increment, m_pi);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
    chk("sweep_cycles", sweep_cycles, m_cyc);
`endif
  end

  logic [63:0] obs[$];
  logic [63:0] expq[$];
  bit          got_done;

  task automatic run_sweep(input logic [63:0] s, input logic [63:0] e, input logic [63:0] st,
                           input logic [15:0] dw, input bit md, input int nobs);
    bit fin = 0;
    start_increment = s; stop_increment = e; step_increment = st;
    dwell_samples = dw; mode = md;
    obs.delete(); got_done = 0;
    start = 1; @(negedge clk); start = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy && sample_clk_ce) obs.push_back(phase_increment);
      if (done) begin got_done = 1; fin = 1; break; end
      if (nobs != 0 && obs.size() >= nobs) begin fin = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL sweep_timeout actual=timeout required=finish"); end
  endtask

  task automatic check_seq(input string nm);
    chk({nm, "_len"}, obs.size(), expq.size());
    foreach (expq[i]) if (i < obs.size()) chk(nm, obs[i], expq[i]);
  endtask

  task automatic do_reset(input logic [15:0] div);
    arst = 1; ce_divider = div;
    repeat (2) @(negedge clk);
    arst = 0;
  endtask

  initial begin
    int n;
    bit ok;
    arst = 1; ce_divider = 16'd3; start = 0; abort = 0; mode = 0;
    start_increment = 0; stop_increment = 0; step_increment = 0; dwell_samples = 0;

    // Divider: first pulse 4 clocks after release, then every 4 clocks.
    repeat (2) @(negedge clk);
    chk("rst_pi", phase_increment, 64'd0);
    chk("rst_ce", sample_clk_ce, 1'b0);
    arst = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!sample_clk_ce && n < 20);
    chk("first_ce", n, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!sample_clk_ce && n < 20);
    chk("ce_period", n, 4);

    do_reset(16'd0);
    ok = 1;
    repeat (5) begin @(negedge clk); ok &= sample_clk_ce; end
    chk("ce_every_clk", ok, 1'b1);

    // Single up-sweep.
    run_sweep(100, 130, 10, 1, 0, 0);
    expq = '{64'd100, 64'd100, 64'd110, 64'd110, 64'd120, 64'd120, 64'd130, 64'd130};
    check_seq("single_seq");
    chk("single_done", got_done, 1'b1);
    chk("busy_fall", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_stop", phase_increment, 64'd130);

    // Clamp at stop, with the divider slowed down.
    do_reset(16'd2);
    run_sweep(100, 125, 10, 0, 0, 0);
    expq = '{64'd100, 64'd110, 64'd120, 64'd125};
    check_seq("clamp_seq");

    // A zero step jumps straight to the bound; an inverted range holds start.
    run_sweep(100, 130, 0, 0, 0, 0);
    expq = '{64'd100, 64'd130};
    check_seq("step0_seq");
    run_sweep(130, 100, 10, 0, 0, 0);
    expq = '{64'd130};
    check_seq("inverted_seq");

    // Triangle sweep.
    do_reset(16'd0);
    run_sweep(0, 20, 10, 0, 1, 9);
    expq = '{64'd0, 64'd10, 64'd20, 64'd20, 64'd10, 64'd0, 64'd0, 64'd10, 64'd20};
    check_seq("tri_seq");
`ifdef PHASE_SWEEP_CYCLE_COUNT_EN
    chk("tri_cycles", sweep_cycles, 16'd1);
`endif
    abort = 1; @(negedge clk); abort = 0;
    chk("tri_abort_busy", busy, 1'b0);

    // Abort mid-sweep at 110.
    start_increment = 100; stop_increment = 130; step_increment = 10;
    dwell_samples = 1; mode = 0;
    start = 1; @(negedge clk); start = 0;
    n = 0;
    while (phase_increment != 64'd110 && n < 50) begin @(negedge clk); n++; end
    chk("abort_reach110", phase_increment, 64'd110);
    abort = 1; @(negedge clk); abort = 0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_pi", phase_increment, 64'd110);
    ok = 0;
    repeat (6) begin @(negedge clk); ok |= done; end
    chk("abort_no_done", ok, 1'b0);

    // Start and abort in the same cycle.
    start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
    ok = 0;
    repeat (3) begin ok |= busy; @(negedge clk); end
    chk("collide_busy", ok, 1'b0);

    // Overflow saturates to stop.
    run_sweep(64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFF, 16, 0, 0, 0);
    expq = '{64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF};
    check_seq("ovf_seq");

    // Reset mid-sweep.
    start_increment = 64'hFFFF_FFFF_FFFF_FFEC; dwell_samples = 5;
    start = 1; @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    arst = 1; @(negedge clk);
    chk("midrst_pi", phase_increment, 64'd0);
    chk("midrst_busy", busy, 1'b0);
    arst = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sweep_controller.md
Name: phase_sweep_controller

Overview:
- Sits directly upstream of the LUT sine generator and drives its sample_clk_ce and phase_increment inputs.
- Produces a free-running sample clock-enable by dividing clk.
- Steps phase_increment linearly from a start value to a stop value, dwelling a programmable number of samples at each step.
- Supports a single up-sweep or a continuous triangle (up/down) sweep, used for filter/mixer frequency-response sweeps in the SDR chain.

Parameters:
- PHASE_WIDTH, 64, width of every increment value; matches the generator's phase accumulator.
- CE_DIV_WIDTH, 16, width of the clock-enable divider.
- DWELL_WIDTH, 16, width of the per-step dwell count.

Ports:
- clk  input  1  system clock
- arst  input  1  synchronous active-high reset, sampled on rising clk
- ce_divider  input  CE_DIV_WIDTH  sample_clk_ce period minus 1, in clk cycles
- start  input  1  single-cycle request to begin a sweep
- abort  input  1  single-cycle request to stop the sweep
- mode  input  1  0 = single up-sweep; 1 = continuous triangle
- start_increment  input  PHASE_WIDTH  unsigned sweep low bound
- stop_increment  input  PHASE_WIDTH  unsigned sweep high bound
- step_increment  input  PHASE_WIDTH  unsigned step size
- dwell_samples  input  DWELL_WIDTH  samples per step minus 1
- sample_clk_ce  output  1  one-clk pulse every ce_divider+1 clks
- phase_increment  output  PHASE_WIDTH  registered increment to the generator
- busy  output  1  high in UP or DOWN
- done  output  1  one-clk pulse when a mode-0 sweep completes

Behaviour:
- Reset (arst=1 at clk edge):
  - outputs: sample_clk_ce=0, phase_increment=0, busy=0, done=0
  - internal: divider counter=0, dwell counter=0, state=IDLE
- CE divider:
  - Counter increments every clk regardless of FSM state.
  - When counter == ce_divider: sample_clk_ce=1 for that cycle and the counter returns to 0.
  - ce_divider=0 -> sample_clk_ce high every cycle.
  - First pulse appears ce_divider+1 cycles after reset release.
  - ce_divider is compared live; if it is lowered below the current count, the counter wraps at 2^CE_DIV_WIDTH.
- FSM states: IDLE, UP, DOWN.
- IDLE:
  - phase_increment holds its last value.
  - start=1 (and abort=0):
    - latch start/stop/step/dwell/mode into shadow registers
    - phase_increment <= start_increment
    - dwell counter <= 0
    - state <= UP
    - busy=1 from the next cycle
  - Inputs are ignored outside IDLE except abort.
- Dwell:
  - The dwell counter advances only on sample_clk_ce.
  - A step expires on the CE where dwell counter == latched dwell. Each value is therefore held exactly dwell+1 CE pulses; dwell=0 gives one sample per step.
  - On expiry the counter clears to 0.
- UP expiry:
  - If phase_increment >= stop:
    - mode 0: done=1 for one cycle, state <= IDLE, phase_increment holds stop.
    - mode 1: state <= DOWN.
  - Else: phase_increment <= min(phase_increment + step, stop).
  - The sum is computed in PHASE_WIDTH+1 bits so overflow saturates to stop.
- DOWN expiry:
  - If phase_increment <= start: state <= UP.
  - Else: phase_increment <= max(phase_increment - step, start).
  - The subtraction is computed with a borrow bit; underflow saturates to start.
- Degenerate cases:
  - step=0 is latched as (stop - start), so the sweep jumps directly to the bound.
  - stop < start (unsigned) at start: value = start, one dwell in UP, then treated as reached. Mode 0 finishes; mode 1 alternates with no value change.
- Update timing: phase_increment changes only on an edge where sample_clk_ce=1 (plus the start load), so the generator always samples a stable value.
- Abort:
  - abort=1 in any state -> state <= IDLE next edge; phase_increment holds; no done pulse; dwell counter cleared.
  - start and abort in the same cycle: abort wins and no sweep starts.
- Reset mid-sweep: arst=1 forces the full reset values on that edge, including phase_increment=0.

Optional Feature:
- Macro PHASE_SWEEP_CYCLE_COUNT_EN.
- Defined: adds output sweep_cycles [15:0]:
  - cleared on accepted start
  - increments on each DOWN->UP transition (one completed triangle)
  - saturates at 16'hFFFF
  - holds on abort
  - reset to 0
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- CE divider: arst 2 cycles, ce_divider=3 -> first sample_clk_ce 4 clks after reset release, then every 4 clks; with ce_divider=0, high every clk.
- Single sweep: start=100, stop=130, step=10, dwell=1, mode 0, ce_divider=0 -> phase_increment 100,100,110,110,120,120,130,130 on successive CEs; done pulses once; busy falls the same cycle; value stays 130.
- Clamp: start=100, stop=125, step=10, dwell=0, mode 0 -> sequence 100,110,120,125, then done.
- Triangle: start=0, stop=20, step=10, dwell=0, mode 1 -> 0,10,20,20,10,0,0,10,20... With the macro defined, sweep_cycles reads 1 after the first return to UP.
- Abort/start collision:
  - abort mid-UP at value 110 -> IDLE next edge, busy=0, phase_increment stays 110, no done.
  - start and abort in the same cycle from IDLE -> busy stays 0.
- Overflow and reset: start=2^64-20, stop=2^64-1, step=16, mode 0 -> values 2^64-20, 2^64-4, 2^64-1; no wrap. Asserting arst mid-sweep -> phase_increment=0, busy=0 next edge.
